// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// pc_gen_if : redirect/stall request bundle and PC/RAS status for pc_gen
// Revision  : 1.0
// ============================================================================
interface pc_gen_if #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
);
   logic                         stall;
   logic                         br_valid;
   logic [WIDTH-1:0]             br_target;
   logic                         jmp_valid;
   logic                         jmp_call;
   logic [WIDTH-1:0]             jmp_target;
   logic                         ret_valid;
   logic                         trap_valid;
   logic [WIDTH-1:0]             trap_target;
   logic [WIDTH-1:0]             pc_out;
   logic                         pend_valid;
   logic [$clog2(RAS_DEPTH):0]   ras_count;
   logic                         ras_underflow;

   modport master (
      output stall, br_valid, br_target, jmp_valid, jmp_call, jmp_target,
             ret_valid, trap_valid, trap_target,
      input  pc_out, pend_valid, ras_count, ras_underflow
   );

   modport slave (
      input  stall, br_valid, br_target, jmp_valid, jmp_call, jmp_target,
             ret_valid, trap_valid, trap_target,
      output pc_out, pend_valid, ras_count, ras_underflow
   );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : fetch PC generator with prioritised redirects, stall-pending
//          redirect capture and a circular return-address stack
// Revision : 1.0
// ============================================================================
module pc_gen #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               INC       = 4,
   parameter int               RAS_DEPTH = 4
) (
   input  wire logic clk,
   input  wire logic reset,
   pc_gen_if.slave   bus
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [WIDTH-1:0] c_inc      = WIDTH'(INC);
   localparam logic [CNT_W-1:0] c_ras_full = CNT_W'(RAS_DEPTH);

   localparam logic [2:0] c_KIND_JMP  = 3'd0;
   localparam logic [2:0] c_KIND_CALL = 3'd1;
   localparam logic [2:0] c_KIND_RET  = 3'd2;
   localparam logic [2:0] c_KIND_BR   = 3'd3;
   localparam logic [2:0] c_KIND_TRAP = 3'd4;

   logic [WIDTH-1:0] r_pc;
   logic             r_pend_valid;
   logic [2:0]       r_pend_kind;
   logic [WIDTH-1:0] r_pend_target;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0] r_ras_ptr;
   logic [CNT_W-1:0] r_ras_count;
   logic             r_underflow;

   logic             w_live_valid;
   logic [2:0]       w_live_kind;
   logic [WIDTH-1:0] w_live_target;
   logic             w_app_valid;
   logic [2:0]       w_app_kind;
   logic [WIDTH-1:0] w_app_target;
   logic [WIDTH-1:0] w_pc_seq;
   logic [WIDTH-1:0] w_ras_top;
   logic [WIDTH-1:0] w_next_pc;
   logic             w_push;
   logic             w_pop;
   logic             w_underflow;
   logic             w_capture;

   function automatic logic [1:0] f_prio(input logic [2:0] kind);
      case (kind)
         c_KIND_TRAP: f_prio = 2'd3;
         c_KIND_BR:   f_prio = 2'd2;
         c_KIND_RET:  f_prio = 2'd1;
         default:     f_prio = 2'd0;
      endcase
   endfunction

   always_comb begin
      w_live_valid  = bus.trap_valid | bus.br_valid | bus.ret_valid | bus.jmp_valid;
      w_live_kind   = c_KIND_JMP;
      w_live_target = bus.jmp_target;
      if (bus.trap_valid) begin
         w_live_kind   = c_KIND_TRAP;
         w_live_target = bus.trap_target;
      end else if (bus.br_valid) begin
         w_live_kind   = c_KIND_BR;
         w_live_target = bus.br_target;
      end else if (bus.ret_valid) begin
         // Return target is resolved from the RAS only when applied.
         w_live_kind   = c_KIND_RET;
         w_live_target = '0;
      end else if (bus.jmp_valid && bus.jmp_call) begin
         w_live_kind   = c_KIND_CALL;
      end
   end

   // A live trap beats a pending entry; otherwise pending beats live requests.
   always_comb begin
      w_app_valid  = 1'b0;
      w_app_kind   = c_KIND_JMP;
      w_app_target = '0;
      if (bus.trap_valid) begin
         w_app_valid  = 1'b1;
         w_app_kind   = c_KIND_TRAP;
         w_app_target = bus.trap_target;
      end else if (r_pend_valid) begin
         w_app_valid  = 1'b1;
         w_app_kind   = r_pend_kind;
         w_app_target = r_pend_target;
      end else if (w_live_valid) begin
         w_app_valid  = 1'b1;
         w_app_kind   = w_live_kind;
         w_app_target = w_live_target;
      end
   end

   always_comb begin
      w_pc_seq    = r_pc + c_inc;
      w_ras_top   = r_ras[r_ras_ptr - PTR_W'(1)];
      w_next_pc   = w_pc_seq;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_underflow = 1'b0;
      if (bus.stall) begin
         w_next_pc = r_pc;
      end else if (w_app_valid) begin
         case (w_app_kind)
            c_KIND_RET: begin
               if (r_ras_count != '0) begin
                  w_next_pc = w_ras_top;
                  w_pop     = 1'b1;
               end else begin
                  w_underflow = 1'b1;
               end
            end
            c_KIND_CALL: begin
               w_next_pc = w_app_target;
               w_push    = 1'b1;
            end
            default: w_next_pc = w_app_target;
         endcase
      end
   end

   assign w_capture = bus.stall && w_live_valid &&
                      (!r_pend_valid || (f_prio(w_live_kind) >= f_prio(r_pend_kind)));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_VEC;
         r_pend_valid  <= 1'b0;
         r_pend_kind   <= c_KIND_JMP;
         r_pend_target <= '0;
         r_ras_ptr     <= '0;
         r_ras_count   <= '0;
         r_underflow   <= 1'b0;
      end else begin
         r_pc        <= w_next_pc;
         r_underflow <= w_underflow;
         if (bus.stall) begin
            if (w_capture) begin
               r_pend_valid  <= 1'b1;
               r_pend_kind   <= w_live_kind;
               r_pend_target <= w_live_target;
            end
         end else begin
            r_pend_valid <= 1'b0;
         end
         // Full stack: pointer keeps wrapping so the oldest entry is overwritten.
         if (w_push) begin
            r_ras_ptr <= r_ras_ptr + PTR_W'(1);
            if (r_ras_count != c_ras_full) begin
               r_ras_count <= r_ras_count + CNT_W'(1);
            end
         end else if (w_pop) begin
            r_ras_ptr   <= r_ras_ptr - PTR_W'(1);
            r_ras_count <= r_ras_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_ras[r_ras_ptr] <= w_pc_seq;
      end
   end

   assign bus.pc_out        = r_pc;
   assign bus.pend_valid    = r_pend_valid;
   assign bus.ras_count     = r_ras_count;
   assign bus.ras_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// tb_pc_gen : directed stimulus with a queued scoreboard for pc_gen
// Revision  : 1.0
// ============================================================================
module tb_pc_gen;

   typedef struct packed {
      logic [15:0] id;
      logic [31:0] pc;
      logic        pend;
      logic [2:0]  cnt;
      logic        uf;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step     = 0;
   exp_t q[$];

   pc_gen_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

   pc_gen #(
      .WIDTH(32), .RESET_VEC(32'h100), .INC(4), .RAS_DEPTH(4)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic clr();
      bus.stall       = 1'b0;
      bus.br_valid    = 1'b0;
      bus.br_target   = '0;
      bus.jmp_valid   = 1'b0;
      bus.jmp_call    = 1'b0;
      bus.jmp_target  = '0;
      bus.ret_valid   = 1'b0;
      bus.trap_valid  = 1'b0;
      bus.trap_target = '0;
   endtask

   // Expected values describe the state right after the coming rising edge.
   task automatic tick(input logic [31:0] pc, input logic pend,
                       input logic [2:0] cnt, input logic uf);
      exp_t e;
      @(posedge clk);
      e.id = 16'(step); e.pc = pc; e.pend = pend; e.cnt = cnt; e.uf = uf;
      q.push_back(e);
      step++;
      #1;
      clr();
   endtask

   task automatic call(input logic [31:0] t);
      bus.jmp_valid = 1'b1; bus.jmp_call = 1'b1; bus.jmp_target = t;
   endtask

   task automatic jmp(input logic [31:0] t);
      bus.jmp_valid = 1'b1; bus.jmp_target = t;
   endtask

   task automatic trap(input logic [31:0] t);
      bus.trap_valid = 1'b1; bus.trap_target = t;
   endtask

   task automatic br(input logic [31:0] t);
      bus.br_valid = 1'b1; bus.br_target = t;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (bus.pc_out !== e.pc || bus.pend_valid !== e.pend ||
                bus.ras_count !== e.cnt || bus.ras_underflow !== e.uf) begin
               n_fail++;
               $display("FAIL step%0d: got pc=%h pend=%0d cnt=%0d uf=%0d, want pc=%h pend=%0d cnt=%0d uf=%0d",
                        e.id, bus.pc_out, bus.pend_valid, bus.ras_count, bus.ras_underflow,
                        e.pc, e.pend, e.cnt, e.uf);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : driver
      clr();
      reset = 1'b1;
      tick(32'h100, 0, 0, 0);
      reset = 1'b0;
      tick(32'h104, 0, 0, 0);
      tick(32'h108, 0, 0, 0);
      tick(32'h10C, 0, 0, 0);
      call(32'h800);           tick(32'h800, 0, 1, 0);
      reset = 1'b1;            tick(32'h100, 0, 0, 0);
      reset = 1'b0;

      br(32'h200); jmp(32'h300);              tick(32'h200, 0, 0, 0);
      br(32'h200); jmp(32'h300); trap(32'h40); tick(32'h40, 0, 0, 0);

      bus.stall = 1'b1; br(32'h500);  tick(32'h40, 1, 0, 0);
      bus.stall = 1'b1; jmp(32'h600); tick(32'h40, 1, 0, 0);
      bus.stall = 1'b1;               tick(32'h40, 1, 0, 0);
      jmp(32'h700);                   tick(32'h500, 0, 0, 0);
      tick(32'h504, 0, 0, 0);

      bus.stall = 1'b1; jmp(32'h900);  tick(32'h504, 1, 0, 0);
      bus.stall = 1'b1; trap(32'h80);  tick(32'h504, 1, 0, 0);
      tick(32'h80, 0, 0, 0);
      bus.stall = 1'b1; br(32'hA00);   tick(32'h80, 1, 0, 0);
      trap(32'hC0);                    tick(32'hC0, 0, 0, 0);

      jmp(32'h1000);   tick(32'h1000, 0, 0, 0);
      call(32'h2000);  tick(32'h2000, 0, 1, 0);
      call(32'h3000);  tick(32'h3000, 0, 2, 0);
      bus.ret_valid = 1'b1; tick(32'h2004, 0, 1, 0);
      bus.ret_valid = 1'b1; tick(32'h1004, 0, 0, 0);
      bus.ret_valid = 1'b1; tick(32'h1008, 0, 0, 1);
      tick(32'h100C, 0, 0, 0);

      call(32'h4000);                         tick(32'h4000, 0, 1, 0);
      bus.stall = 1'b1; bus.ret_valid = 1'b1; tick(32'h4000, 1, 1, 0);
      tick(32'h1010, 0, 0, 0);

      call(32'h5000); tick(32'h5000, 0, 1, 0);
      call(32'h5100); tick(32'h5100, 0, 2, 0);
      call(32'h5200); tick(32'h5200, 0, 3, 0);
      call(32'h5300); tick(32'h5300, 0, 4, 0);
      call(32'h5400); tick(32'h5400, 0, 4, 0);
      bus.ret_valid = 1'b1; tick(32'h5304, 0, 3, 0);
      bus.ret_valid = 1'b1; tick(32'h5204, 0, 2, 0);
      bus.ret_valid = 1'b1; tick(32'h5104, 0, 1, 0);
      bus.ret_valid = 1'b1; tick(32'h5004, 0, 0, 0);
      bus.ret_valid = 1'b1; tick(32'h5008, 0, 0, 1);

      jmp(32'hFFFF_FFFC); tick(32'hFFFF_FFFC, 0, 0, 0);
      tick(32'h0000_0000, 0, 0, 0);
      tick(32'h0000_0004, 0, 0, 0);

      bus.stall = 1'b1; trap(32'h60); tick(32'h4, 1, 0, 0);
      bus.stall = 1'b1; reset = 1'b1; tick(32'h100, 0, 0, 0);
      reset = 1'b0;                   tick(32'h104, 0, 0, 0);

      repeat (2) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the plain PC register.
- Holds the fetch PC and computes the next PC from sequential increment, branch, jump/call, return and trap redirects, in a fixed priority.
- Supports stall. A redirect that arrives during a stall is kept in a pending register until the stall clears.
- A small return-address stack (RAS) provides call/return targets.
- Sits between the fetch stage and instruction memory.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- INC, 4, sequential increment added to the PC.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC this cycle.
- br_valid  in  1  taken branch redirect.
- br_target  in  WIDTH  branch target.
- jmp_valid  in  1  jump redirect.
- jmp_call  in  1  qualifies jmp_valid as a call, which pushes the return address.
- jmp_target  in  WIDTH  jump target.
- ret_valid  in  1  return; target is the RAS top.
- trap_valid  in  1  trap redirect.
- trap_target  in  WIDTH  trap vector.
- pc_out  out  WIDTH  current fetch PC.
- pend_valid  out  1  a redirect is pending.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_underflow  out  1  one-cycle pulse: a return was applied with the RAS empty.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset). All state changes on the rising clk edge only.
- Reset values:
  - pc_out = RESET_VEC.
  - pend_valid = 0.
  - ras_count = 0.
  - ras_underflow = 0.
  - RAS pointer = 0.
- Reset overrides every other input in the same cycle, including mid-stall and with a redirect pending.
- Live redirect priority, highest first: trap > branch > return > jump/call > sequential.
- Only the single highest-priority live request is considered each cycle; lower-priority requests in the same cycle are dropped.
- Pending register contents: target (WIDTH), kind (trap / branch / ret / jmp / call), and valid.
- A pending ret or call has its RAS effect applied when the pending redirect is applied, not when it is captured.
- Cycle with stall=1:
  - pc_out holds its value.
  - If a live request exists, it is captured into pending if either (a) pending is empty, or (b) the live kind's priority ≥ the stored kind's priority. Otherwise it is dropped.
  - Capturing replaces any stored entry.
  - ret targets are not resolved at capture time.
  - The RAS is unchanged.
- Cycle with stall=0: next PC is chosen in this order:
  1. Live trap: pc_out ← trap_target, and pending is cleared.
  2. Else pending valid: apply the pending kind, then clear pending. All live non-trap requests this cycle are dropped.
  3. Else highest-priority live request.
  4. Else pc_out ← pc_out + INC.
- Applying each kind:
  - trap / branch / jmp: pc_out ← target.
  - call: pc_out ← target, and push (pc_out + INC) of the current cycle.
  - ret with ras_count > 0: pc_out ← RAS top, then pop.
  - ret with ras_count = 0: pc_out ← pc_out + INC, and ras_underflow = 1 for one cycle.
- Arithmetic: addition is modulo 2^WIDTH. PC = all-ones − INC + 1 wraps to 0 silently.
- RAS behaviour:
  - Circular buffer.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop decrements ras_count.
  - No simultaneous push and pop is possible, since only one redirect is applied per cycle.
  - A trap does not modify the RAS.
- pend_valid is registered; it reflects pending state after the edge.

Test Plan:
- Reset with RESET_VEC=0x100, then 3 idle cycles → pc_out = 0x100, 0x104, 0x108, 0x10C. Assert reset mid-run → next pc_out = 0x100, pend_valid = 0, ras_count = 0.
- br_valid with br_target=0x200, together with jmp_valid and jmp_target=0x300, same cycle → pc_out = 0x200. Same cycle plus trap_valid with trap_target=0x40 → pc_out = 0x40.
- stall=1 for 3 cycles; br to 0x500 in cycle 1, jmp to 0x600 in cycle 2 → jmp dropped (lower priority), pc_out held, pend_valid = 1. First unstalled cycle with jmp to 0x700 live → pc_out = 0x500, pend_valid = 0.
- At pc 0x1000, call to 0x2000; then at 0x2000, call to 0x3000; then ret, ret → pc_out sequence 0x2000, 0x3000, 0x2004, 0x1004, and ras_count goes 1, 2, 1, 0. A third ret → pc_out = 0x1008, ras_underflow pulses for 1 cycle.
- RAS_DEPTH=4; 5 nested calls, then 5 rets → first 4 rets return to the most recent 4 return addresses; the 5th ret underflows. ras_count never exceeds 4.
- Set pc_out = 0xFFFFFFFC with no redirect → next pc_out = 0x00000000. Pending trap captured during stall, then reset asserted → pending cleared and pc_out = RESET_VEC.
